pipe_decode: RTL
================

# pipe_decode

Parametrised pipelined decode stage for the Y86-64 PIPE processor. It contains the D pipeline register, which captures fetch outputs, and the E pipeline register, which holds decode results. Between them it does register-ID selection, register-file read and five-source operand forwarding. It also flags load-use and ret hazards to the pipeline control block, which drives stall and bubble back in.

## Interface
Parameters:
- DW, 64, data width of registers and values
- NREG, 15, number of architectural registers; `regis` is NREG*DW bits, register k at [k*DW+DW-1 : k*DW]
- RW, 4, register-ID width; ID 2^RW-1 (15) is RNONE

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- f_icode, f_ifun  in  4 each  fetched instruction code/function
- f_rA, f_rB  in  RW each  fetched register IDs
- f_valC, f_valP  in  DW each  constant and next PC
- f_stat  in  3  status (AOK=1, HLT=2, ADR=3, INS=4)
- D_stall, D_bubble, E_bubble  in  1 each  pipeline control
- regis  in  NREG*DW  flattened register-file contents
- e_dstE  in  RW, e_valE  in  DW  execute-stage forward source
- M_dstM  in  RW, m_valM  in  DW  memory read forward source
- M_dstE  in  RW, M_valE  in  DW
- W_dstM, W_dstE  in  RW, W_valM, W_valE  in  DW
- d_srcA, d_srcB  out  RW each  combinational source IDs of the instruction in D
- load_use  out  1  combinational load-use hazard
- ret_in_pipe  out  1  combinational: ret in D or E
- E_icode, E_ifun  out  4 each
- E_stat  out  3
- E_valC, E_valA, E_valB  out  DW each
- E_dstE, E_dstM, E_srcA, E_srcB  out  RW each

## Operation
- D register fields: icode, ifun, rA, rB, valC, valP, stat.
- ID selection, combinational from the D register; any field not set below is RNONE:
  - 2 cmovXX: srcA=rA, dstE=rB
  - 3 irmovq: dstE=rB
  - 4 rmmovq: srcA=rA, srcB=rB
  - 5 mrmovq: srcB=rB, dstM=rA
  - 6 OPq: srcA=rA, srcB=rB, dstE=rB
  - 8 call: srcB=dstE=4
  - 9 ret: srcA=srcB=dstE=4
  - 10 pushq: srcA=rA, srcB=dstE=4
  - 11 popq: srcA=srcB=dstE=4, dstM=rA
- Operand read for a source ID s, first match wins:
  - s==RNONE → 0
  - s==e_dstE → e_valE
  - s==M_dstM → m_valM
  - s==M_dstE → M_valE
  - s==W_dstM → W_valM
  - s==W_dstE → W_valE
  - s<NREG → regis[s]
  - else (s≥NREG, not RNONE) → 0
- A forward source whose dst is RNONE never matches.
- d_valA = D.valP for icode 7 (jXX) and 8 (call), overriding forwarding; otherwise the read of srcA. d_valB is the read of srcB.
- load_use = (E_icode==5 or 11) and E_dstM != RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
- ret_in_pipe = (D.icode==9) or (E_icode==9).
- Unknown icode (0, 12-15) gets all IDs RNONE and operands 0. The fetch stage has already set stat=INS; stat passes through unchanged.

## Timing
- Rst at an edge has priority over everything:
  - D register loads a nop: icode=1, ifun=0, rA=rB=RNONE, valC=valP=0, stat=1.
  - E register loads a bubble: icode=1, ifun=0, valC=valA=valB=0, all IDs RNONE, stat=1.
- D register, per non-reset edge:
  - D_stall=1: hold current contents. Stall wins if D_bubble is also 1.
  - D_bubble=1: load the nop.
  - Otherwise: load the f_* inputs.
- E register, per non-reset edge:
  - E_bubble=1: load the bubble.
  - Otherwise: load icode, ifun, stat, valC, d_valA, d_valB, dstE, dstM, srcA, srcB decoded from D.
- Latency: a fetched instruction appears on E_* outputs two edges after being presented on f_*, with no stalls.
- Forwarding is sampled in the same cycle as E capture. The register-file value used is `regis` as seen that cycle; a write-back in the same cycle is covered by the W forward sources.
- Hazard outputs depend only on the current D and E registers. No combinational path from f_* inputs.

## Test plan
- Reset: Rst=1 for one edge → E_icode=1, E_dstE=E_dstM=15, E_valA=0, E_stat=1; load_use=0, ret_in_pipe=0.
- OPq forwarding priority: regis[3]=5, W_dstE=3/W_valE=7, M_dstE=3/M_valE=9, e_dstE=3/e_valE=11; instruction 0x60 rA=3 rB=3 → E_valA=E_valB=11 and E_dstE=3. Drop e_dstE to 15 → 9.
- call: f_icode=8, f_valP=0x40, regis[4]=0x100 → two edges later E_valA=0x40, E_valB=0x100, E_dstE=4, E_srcA=15.
- Load-use: mrmovq rA=2 in E, then OPq rA=2 in D → load_use=1. Drive D_stall=1, E_bubble=1 → D holds the OPq and E_icode=1 next cycle. Afterwards m_valM is forwarded into E_valA.
- Control priority: D_stall=D_bubble=1 holds D. D_bubble alone gives D.icode=1. Rst asserted mid-stall clears both registers to reset values.
- popq with rA=15 → E_dstM=15 and load_use never asserts. Source ID 14 with NREG=14 reads 0.

Source files
------------

// File: rtl/pipe_decode.sv
// ---------------------------------------------------------------------------
// pipe_decode
//
// Decode stage of the Y86-64 PIPE processor. Holds the D pipeline register
// (fetch results) and the E pipeline register (decode results). Between them
// it selects source/destination register IDs, reads the register file and
// forwards operands from five later-stage sources. It also reports load-use
// and ret hazards to the pipeline control block.
//
// Parameters
//   DW    data width
//   NREG  number of architectural registers present in `regis`
//   RW    register-ID width; the all-ones ID is RNONE
//
// Ports
//   Clk, Rst                      clock, synchronous active-high reset
//   f_icode/f_ifun/f_rA/f_rB/
//   f_valC/f_valP/f_stat          fetch-stage outputs captured into D
//   D_stall, D_bubble, E_bubble   pipeline control
//   regis                         flattened register-file contents
//   e_dstE/e_valE, M_dstM/m_valM,
//   M_dstE/M_valE, W_dstM/W_valM,
//   W_dstE/W_valE                 forwarding sources, highest priority first
//   d_srcA, d_srcB                source IDs of the instruction in D
//   load_use, ret_in_pipe         hazard flags (from D/E registers only)
//   E_*                           E pipeline register contents
// ---------------------------------------------------------------------------
module pipe_decode #(
    parameter int DW   = 64,
    parameter int NREG = 15,
    parameter int RW   = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [3:0]         f_icode,
    input  logic [3:0]         f_ifun,
    input  logic [RW-1:0]      f_rA,
    input  logic [RW-1:0]      f_rB,
    input  logic [DW-1:0]      f_valC,
    input  logic [DW-1:0]      f_valP,
    input  logic [2:0]         f_stat,
    input  logic               D_stall,
    input  logic               D_bubble,
    input  logic               E_bubble,
    input  logic [NREG*DW-1:0] regis,
    input  logic [RW-1:0]      e_dstE,
    input  logic [DW-1:0]      e_valE,
    input  logic [RW-1:0]      M_dstM,
    input  logic [DW-1:0]      m_valM,
    input  logic [RW-1:0]      M_dstE,
    input  logic [DW-1:0]      M_valE,
    input  logic [RW-1:0]      W_dstM,
    input  logic [RW-1:0]      W_dstE,
    input  logic [DW-1:0]      W_valM,
    input  logic [DW-1:0]      W_valE,
    output logic [RW-1:0]      d_srcA,
    output logic [RW-1:0]      d_srcB,
    output logic               load_use,
    output logic               ret_in_pipe,
    output logic [3:0]         E_icode,
    output logic [3:0]         E_ifun,
    output logic [2:0]         E_stat,
    output logic [DW-1:0]      E_valC,
    output logic [DW-1:0]      E_valA,
    output logic [DW-1:0]      E_valB,
    output logic [RW-1:0]      E_dstE,
    output logic [RW-1:0]      E_dstM,
    output logic [RW-1:0]      E_srcA,
    output logic [RW-1:0]      E_srcB
);

    localparam logic [RW-1:0] RNONE = '1;
    localparam logic [RW-1:0] RRSP  = RW'(4);

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_CMOV   = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [2:0] S_AOK = 3'd1;

    // -----------------------------------------------------------------------
    // D pipeline register
    // -----------------------------------------------------------------------
    logic [3:0]    r_d_icode;
    logic [3:0]    r_d_ifun;
    logic [RW-1:0] r_d_rA;
    logic [RW-1:0] r_d_rB;
    logic [DW-1:0] r_d_valC;
    logic [DW-1:0] r_d_valP;
    logic [2:0]    r_d_stat;

    always_ff @(posedge Clk) begin
        // Reset first; a stall then holds D even if a bubble is also requested.
        if (Rst || (!D_stall && D_bubble)) begin
            r_d_icode <= I_NOP;
            r_d_ifun  <= 4'd0;
            r_d_rA    <= RNONE;
            r_d_rB    <= RNONE;
            r_d_valC  <= '0;
            r_d_valP  <= '0;
            r_d_stat  <= S_AOK;
        end else if (!D_stall) begin
            r_d_icode <= f_icode;
            r_d_ifun  <= f_ifun;
            r_d_rA    <= f_rA;
            r_d_rB    <= f_rB;
            r_d_valC  <= f_valC;
            r_d_valP  <= f_valP;
            r_d_stat  <= f_stat;
        end
    end

    // -----------------------------------------------------------------------
    // Register-ID selection
    // -----------------------------------------------------------------------
    logic [RW-1:0] w_srcA;
    logic [RW-1:0] w_srcB;
    logic [RW-1:0] w_dstE;
    logic [RW-1:0] w_dstM;

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (r_d_icode)
            I_CMOV: begin
                w_srcA = r_d_rA;
                w_dstE = r_d_rB;
            end
            I_IRMOVQ: begin
                w_dstE = r_d_rB;
            end
            I_RMMOVQ: begin
                w_srcA = r_d_rA;
                w_srcB = r_d_rB;
            end
            I_MRMOVQ: begin
                w_srcB = r_d_rB;
                w_dstM = r_d_rA;
            end
            I_OPQ: begin
                w_srcA = r_d_rA;
                w_srcB = r_d_rB;
                w_dstE = r_d_rB;
            end
            I_CALL: begin
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_RET: begin
                w_srcA = RRSP;
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_PUSHQ: begin
                w_srcA = r_d_rA;
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_POPQ: begin
                w_srcA = RRSP;
                w_srcB = RRSP;
                w_dstE = RRSP;
                w_dstM = r_d_rA;
            end
            default: ;
        endcase
    end

    assign d_srcA = w_srcA;
    assign d_srcB = w_srcB;

    // -----------------------------------------------------------------------
    // Register-file read with forwarding; one read port per source operand.
    // -----------------------------------------------------------------------
    logic [DW-1:0]   w_regs [NREG];
    logic [2*RW-1:0] w_src_flat;
    logic [2*DW-1:0] w_rd_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_unpack
            assign w_regs[gi] = regis[gi*DW +: DW];
        end
    endgenerate

    assign w_src_flat = {w_srcB, w_srcA};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [RW-1:0] w_s;
            logic [DW-1:0] w_file;
            logic [DW-1:0] w_val;

            assign w_s = w_src_flat[gi*RW +: RW];

            // IDs at or above NREG (other than RNONE) have no backing register
            // and fall through to zero.
            always_comb begin
                w_file = '0;
                for (int k = 0; k < NREG; k++) begin
                    if (w_s == RW'(k)) begin
                        w_file = w_regs[k];
                    end
                end
            end

            // RNONE is tested first, so a forward source whose dst is RNONE
            // can never match a real source ID below.
            always_comb begin
                if (w_s == RNONE) begin
                    w_val = '0;
                end else if (w_s == e_dstE) begin
                    w_val = e_valE;
                end else if (w_s == M_dstM) begin
                    w_val = m_valM;
                end else if (w_s == M_dstE) begin
                    w_val = M_valE;
                end else if (w_s == W_dstM) begin
                    w_val = W_valM;
                end else if (w_s == W_dstE) begin
                    w_val = W_valE;
                end else begin
                    w_val = w_file;
                end
            end

            assign w_rd_flat[gi*DW +: DW] = w_val;
        end
    endgenerate

    // jXX and call carry the fall-through PC down the pipe in valA.
    logic [DW-1:0] w_valA;
    logic [DW-1:0] w_valB;

    assign w_valA = (r_d_icode == I_JXX || r_d_icode == I_CALL) ? r_d_valP
                                                                 : w_rd_flat[0 +: DW];
    assign w_valB = w_rd_flat[DW +: DW];

    // -----------------------------------------------------------------------
    // E pipeline register
    // -----------------------------------------------------------------------
    logic [3:0]    r_e_icode;
    logic [3:0]    r_e_ifun;
    logic [2:0]    r_e_stat;
    logic [DW-1:0] r_e_valC;
    logic [DW-1:0] r_e_valA;
    logic [DW-1:0] r_e_valB;
    logic [RW-1:0] r_e_dstE;
    logic [RW-1:0] r_e_dstM;
    logic [RW-1:0] r_e_srcA;
    logic [RW-1:0] r_e_srcB;

    always_ff @(posedge Clk) begin
        if (Rst || E_bubble) begin
            r_e_icode <= I_NOP;
            r_e_ifun  <= 4'd0;
            r_e_stat  <= S_AOK;
            r_e_valC  <= '0;
            r_e_valA  <= '0;
            r_e_valB  <= '0;
            r_e_dstE  <= RNONE;
            r_e_dstM  <= RNONE;
            r_e_srcA  <= RNONE;
            r_e_srcB  <= RNONE;
        end else begin
            r_e_icode <= r_d_icode;
            r_e_ifun  <= r_d_ifun;
            r_e_stat  <= r_d_stat;
            r_e_valC  <= r_d_valC;
            r_e_valA  <= w_valA;
            r_e_valB  <= w_valB;
            r_e_dstE  <= w_dstE;
            r_e_dstM  <= w_dstM;
            r_e_srcA  <= w_srcA;
            r_e_srcB  <= w_srcB;
        end
    end

    assign E_icode = r_e_icode;
    assign E_ifun  = r_e_ifun;
    assign E_stat  = r_e_stat;
    assign E_valC  = r_e_valC;
    assign E_valA  = r_e_valA;
    assign E_valB  = r_e_valB;
    assign E_dstE  = r_e_dstE;
    assign E_dstM  = r_e_dstM;
    assign E_srcA  = r_e_srcA;
    assign E_srcB  = r_e_srcB;

    // -----------------------------------------------------------------------
    // Hazard detection, purely from the D and E registers.
    // -----------------------------------------------------------------------
    assign load_use = (r_e_icode == I_MRMOVQ || r_e_icode == I_POPQ) &&
                      (r_e_dstM != RNONE) &&
                      (r_e_dstM == w_srcA || r_e_dstM == w_srcB);

    assign ret_in_pipe = (r_d_icode == I_RET) || (r_e_icode == I_RET);

endmodule
